gen_scheduler: RTL and testbench
================================

// Module: gen_scheduler
// PURPOSE
//  Sequences one Game-of-Life generation over the ping-pong BRAM pair (A/B). Issues toroidal
//  row fetches from the current bank into the line buffer, generates write addresses for
//  parallel next-state rows into the other bank, then swaps banks. Sits between frame timing,
//  pause/step control and the mode selector / BRAM muxing.
// PARAMETERS
//  Y_SIZE      720   rows per grid
//  Y_WIDTH     10    row address width, clog2(Y_SIZE)
//  CNT_WIDTH   16    generation counter width
//  WDOG_CYCLES 4096  DRAIN timeout; used only with GEN_SCHED_WATCHDOG_EN
// PORTS
//  clk          in  1          system clock
//  rst          in  1          async, active-high reset
//  frame_tick   in  1          1-cycle pulse: run a generation if not paused
//  pause        in  1          pause flag; sampled only in IDLE
//  step         in  1          1-cycle pulse: run exactly one generation even when paused
//  fetch_valid  out 1          fetch request valid
//  fetch_ready  in  1          line buffer accepts fetch_addr
//  fetch_addr   out Y_WIDTH    row to read from current bank
//  result_valid in  1          next-state row available from compute
//  wr_en        out 1          write enable to next bank
//  wr_addr      out Y_WIDTH    next-state row address
//  bank_sel     out 1          current (read) bank: 0=A, 1=B; writes go to ~bank_sel
//  busy         out 1          high in any state except IDLE
//  gen_done     out 1          1-cycle pulse when the swap occurs
//  gen_count    out CNT_WIDTH  completed generations, wraps
//  wr_overflow  out 1          sticky: result_valid seen after Y_SIZE writes
//  wdog_err     out 1          sticky watchdog error (0 without macro)
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; fetch/write counters 0; sticky flags cleared.
//  FSM: IDLE -> FETCH -> DRAIN -> SWAP -> IDLE.
//   IDLE: go FETCH next cycle on step, or on frame_tick && !pause. Simultaneous tick+step = one gen.
//   FETCH: fetch_valid=1. Sequence: Y_SIZE-1, 0, 1, ..., Y_SIZE-1, 0 (Y_SIZE+2 fetches).
//     Advance only on fetch_valid && fetch_ready; fetch_addr held stable while stalled.
//     Last accepted fetch -> DRAIN.
//   DRAIN: fetch_valid=0; wait until wr count == Y_SIZE -> SWAP.
//   SWAP: one cycle; bank_sel toggles, gen_done=1, gen_count+1 (mod 2^CNT_WIDTH) -> IDLE.
//  Writes (FETCH or DRAIN): wr_en = result_valid && wr_cnt<Y_SIZE; wr_addr = wr_cnt (comb);
//   wr_cnt increments on wr_en. result_valid at wr_cnt==Y_SIZE or in IDLE/SWAP: wr_en=0, set wr_overflow.
//  Counters clear on IDLE->FETCH. Pause asserted mid-generation: generation completes.
//  frame_tick/step while busy: ignored (not queued). Async rst mid-generation: immediate
//   return to reset values incl. bank_sel=0; partial generation discarded.
// CONFIGURATION
//  GEN_SCHED_WATCHDOG_EN defined: DRAIN cycle counter; reaching WDOG_CYCLES -> IDLE without swap,
//   bank_sel/gen_count unchanged, no gen_done, wdog_err set sticky until rst.
//  Undefined: no counter, DRAIN waits indefinitely, wdog_err tied 0.
// STRUCTURE
//  Shared package/header gol_pkg: Y_SIZE/Y_WIDTH defaults, FSM state encodings
//   (IDLE/FETCH/DRAIN/SWAP), bank encodings BANK_A=0/BANK_B=1.
//  Sub-module row_seq: toroidal fetch-address counter (start Y_SIZE-1, wrap at Y_SIZE,
//   done after Y_SIZE+2 accepts). FSM, write counter, flags stay in gen_scheduler.
// TESTING (Y_SIZE=4, Y_WIDTH=2, WDOG_CYCLES=16)
//  Reset, frame_tick, fetch_ready=1, 4 result_valid -> fetch_addr 3,0,1,2,3,0; wr_addr 0..3;
//   gen_done pulse; bank_sel 0->1; gen_count=1; busy low after SWAP.
//  pause=1 + frame_tick -> stays IDLE, busy=0; step pulse -> exactly one gen, gen_count +1.
//  fetch_ready toggled every other cycle -> fetch_addr stable while stalled; same 6-addr sequence.
//  5th result_valid after 4 writes -> wr_en=0, wr_overflow=1 sticky; gen completes normally.
//  rst pulsed during FETCH (after 2 fetches) -> outputs at reset values; next tick restarts at addr 3.
//  Macro on, no result_valid -> 16 cycles in DRAIN then IDLE, wdog_err=1, bank_sel unchanged.

Source files
------------

// File: rtl/gol_pkg.sv
// Shared Game-of-Life definitions: grid defaults, scheduler FSM states, bank encodings.
package gol_pkg;

  localparam int unsigned DEF_Y_SIZE      = 720;
  localparam int unsigned DEF_Y_WIDTH     = 10;
  localparam int unsigned DEF_CNT_WIDTH   = 16;
  localparam int unsigned DEF_WDOG_CYCLES = 4096;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_SWAP  = 2'd3
  } state_e;

  typedef enum logic {
    BANK_A = 1'b0,
    BANK_B = 1'b1
  } bank_e;

endpackage

// File: rtl/row_seq.sv
// Toroidal row fetch sequencer: Y_SIZE-1, 0, 1, ..., Y_SIZE-1, 0 (Y_SIZE+2 accepted fetches).
module row_seq
  import gol_pkg::*;
#(
  parameter int unsigned Y_SIZE  = DEF_Y_SIZE,
  parameter int unsigned Y_WIDTH = DEF_Y_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               accept_i,
  output logic [Y_WIDTH-1:0] addr_o,
  output logic               last_o
);

  // One extra bit so the accept count can reach Y_SIZE+1.
  localparam int unsigned CW = Y_WIDTH + 1;

  logic [Y_WIDTH-1:0] addr_q, addr_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  // Next address: restart on the row above row 0, wrap at Y_SIZE.
  always_comb begin
    addr_d = addr_q;
    cnt_d  = cnt_q;
    if (start_i) begin
      addr_d = Y_WIDTH'(Y_SIZE - 1);
      cnt_d  = '0;
    end else if (accept_i) begin
      cnt_d  = cnt_q + CW'(1);
      addr_d = (addr_q == Y_WIDTH'(Y_SIZE - 1)) ? '0 : addr_q + Y_WIDTH'(1);
    end
  end

  // Address and accept-count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      cnt_q  <= '0;
    end else begin
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign addr_o = addr_q;
  assign last_o = (cnt_q == CW'(Y_SIZE + 1));

endmodule

// File: rtl/gen_scheduler.sv
// Game-of-Life generation scheduler over the A/B ping-pong banks.
// Optional DRAIN watchdog enabled by defining GEN_SCHED_WATCHDOG_EN.
module gen_scheduler
  import gol_pkg::*;
#(
  parameter int unsigned Y_SIZE      = DEF_Y_SIZE,
  parameter int unsigned Y_WIDTH     = DEF_Y_WIDTH,
  parameter int unsigned CNT_WIDTH   = DEF_CNT_WIDTH,
  parameter int unsigned WDOG_CYCLES = DEF_WDOG_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_tick,
  input  logic                 pause,
  input  logic                 step,
  output logic                 fetch_valid,
  input  logic                 fetch_ready,
  output logic [Y_WIDTH-1:0]   fetch_addr,
  input  logic                 result_valid,
  output logic                 wr_en,
  output logic [Y_WIDTH-1:0]   wr_addr,
  output logic                 bank_sel,
  output logic                 busy,
  output logic                 gen_done,
  output logic [CNT_WIDTH-1:0] gen_count,
  output logic                 wr_overflow,
  output logic                 wdog_err
);

  // Write counter must be able to hold Y_SIZE itself.
  localparam int unsigned WCW = Y_WIDTH + 1;

  state_e               state_q, state_d;
  logic [WCW-1:0]       wr_cnt_q, wr_cnt_d;
  bank_e                bank_q, bank_d;
  logic [CNT_WIDTH-1:0] gen_cnt_q, gen_cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 wdog_err_q, wdog_err_d;
  logic                 seq_start, seq_last, fetch_accept;
  logic                 wr_full, writing, wdog_expired;

  assign wr_full      = (wr_cnt_q == WCW'(Y_SIZE));
  assign writing      = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
  assign fetch_accept = (state_q == ST_FETCH) && fetch_ready;

  row_seq #(
    .Y_SIZE  (Y_SIZE),
    .Y_WIDTH (Y_WIDTH)
  ) u_row_seq (
    .clk      (clk),
    .rst      (rst),
    .start_i  (seq_start),
    .accept_i (fetch_accept),
    .addr_o   (fetch_addr),
    .last_o   (seq_last)
  );

`ifdef GEN_SCHED_WATCHDOG_EN
  localparam int unsigned WDW = $clog2(WDOG_CYCLES) + 1;

  logic [WDW-1:0] wdog_q, wdog_d;

  // DRAIN residency counter; cleared whenever the FSM is elsewhere.
  always_comb begin
    wdog_d = '0;
    if (state_q == ST_DRAIN) wdog_d = wdog_q + WDW'(1);
  end

  // Watchdog counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wdog_q <= '0;
    else     wdog_q <= wdog_d;
  end

  assign wdog_expired = (state_q == ST_DRAIN) && (wdog_q == WDW'(WDOG_CYCLES - 1));
`else
  logic [31:0] unused_wdog;
  assign unused_wdog  = 32'(WDOG_CYCLES);
  assign wdog_expired = 1'b0;
`endif

  // Next-state, counters, sticky flags and state-decoded outputs.
  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    bank_d      = bank_q;
    gen_cnt_d   = gen_cnt_q;
    ovf_d       = ovf_q;
    wdog_err_d  = wdog_err_q;
    seq_start   = 1'b0;
    fetch_valid = 1'b0;
    gen_done    = 1'b0;
    busy        = 1'b1;
    wr_en       = result_valid && writing && !wr_full;

    if (wr_en) wr_cnt_d = wr_cnt_q + WCW'(1);
    // Any result not absorbed by a write is an overflow.
    if (result_valid && !wr_en) ovf_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (step || (frame_tick && !pause)) begin
          state_d   = ST_FETCH;
          seq_start = 1'b1;
          wr_cnt_d  = '0;
        end
      end
      ST_FETCH: begin
        fetch_valid = 1'b1;
        if (fetch_ready && seq_last) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (wr_full) begin
          state_d = ST_SWAP;
        end else if (wdog_expired) begin
          state_d    = ST_IDLE;
          wdog_err_d = 1'b1;
        end
      end
      ST_SWAP: begin
        gen_done  = 1'b1;
        bank_d    = bank_e'(~bank_q);
        gen_cnt_d = gen_cnt_q + CNT_WIDTH'(1);
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and bookkeeping registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wr_cnt_q   <= '0;
      bank_q     <= BANK_A;
      gen_cnt_q  <= '0;
      ovf_q      <= 1'b0;
      wdog_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      bank_q     <= bank_d;
      gen_cnt_q  <= gen_cnt_d;
      ovf_q      <= ovf_d;
      wdog_err_q <= wdog_err_d;
    end
  end

  assign wr_addr     = wr_cnt_q[Y_WIDTH-1:0];
  assign bank_sel    = bank_q;
  assign gen_count   = gen_cnt_q;
  assign wr_overflow = ovf_q;
  assign wdog_err    = wdog_err_q;

endmodule

// File: tb/tb_gen_scheduler.sv
// Scoreboard bench for gen_scheduler with a 4-row grid.
module tb_gen_scheduler;

  localparam int unsigned YS = 4;
  localparam int unsigned YW = 2;
  localparam int unsigned CW = 16;
  localparam int unsigned WD = 16;
  localparam int          BOUND = 200;

  logic          clk = 1'b0;
  logic          rst, frame_tick, pause, step, fetch_ready, result_valid;
  logic          fetch_valid, wr_en, bank_sel, busy, gen_done, wr_overflow, wdog_err;
  logic [YW-1:0] fetch_addr, wr_addr;
  logic [CW-1:0] gen_count;

  int checks = 0;
  int errors = 0;
  int fetch_q[$];
  int wr_q[$];
  int gen_q[$];
  int exp_bank = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  gen_scheduler #(
    .Y_SIZE      (YS),
    .Y_WIDTH     (YW),
    .CNT_WIDTH   (CW),
    .WDOG_CYCLES (WD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .frame_tick   (frame_tick),
    .pause        (pause),
    .step         (step),
    .fetch_valid  (fetch_valid),
    .fetch_ready  (fetch_ready),
    .fetch_addr   (fetch_addr),
    .result_valid (result_valid),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .bank_sel     (bank_sel),
    .busy         (busy),
    .gen_done     (gen_done),
    .gen_count    (gen_count),
    .wr_overflow  (wr_overflow),
    .wdog_err     (wdog_err)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input int act);
    checks++;
    errors++;
    $display("FAIL %s unexpected output actual=%0d required=none", name, act);
  endtask

  // Expected toroidal fetch order for a full generation.
  task automatic push_fetch_seq();
    fetch_q.push_back(3); fetch_q.push_back(0); fetch_q.push_back(1);
    fetch_q.push_back(2); fetch_q.push_back(3); fetch_q.push_back(0);
  endtask

  // Monitor: pop and compare whenever the DUT presents a fetch, write or swap.
  logic          prev_stall;
  logic [YW-1:0] prev_addr;
  int            e;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && fetch_valid) check("fetch_hold", fetch_addr, prev_addr);
      if (fetch_valid && fetch_ready) begin
        if (fetch_q.size() == 0) unexpected("fetch_addr", fetch_addr);
        else begin e = fetch_q.pop_front(); check("fetch_addr", fetch_addr, e); end
      end
      if (wr_en) begin
        if (wr_q.size() == 0) unexpected("wr_addr", wr_addr);
        else begin e = wr_q.pop_front(); check("wr_addr", wr_addr, e); end
      end
      if (gen_done) begin
        if (gen_q.size() == 0) unexpected("gen_done", gen_count);
        else begin
          e = gen_q.pop_front();
          check("swap_bank_pre", bank_sel, e / 65536);
          check("swap_count_pre", gen_count, e % 65536);
        end
      end
      prev_stall = fetch_valid && !fetch_ready;
      prev_addr  = fetch_addr;
    end
  end

  // trig: 0=frame_tick, 1=step, 2=both. Pushes expectations, then drives one generation.
  task automatic run_gen(input int trig, input int n_res, input bit stall);
    int cyc;
    int sent;
    push_fetch_seq();
    for (int i = 0; i < n_res && i < int'(YS); i++) wr_q.push_back(i);
    gen_q.push_back(exp_bank * 65536 + exp_count);
    exp_bank  = exp_bank ^ 1;
    exp_count = exp_count + 1;
    @(posedge clk); #1;
    frame_tick = (trig != 1);
    step       = (trig != 0);
    @(posedge clk); #1;
    frame_tick = 1'b0;
    step       = 1'b0;
    cyc  = 0;
    sent = 0;
    while (busy && cyc < BOUND) begin
      result_valid = (sent < n_res);
      if (sent < n_res) sent++;
      fetch_ready = stall ? ((cyc % 2) == 1) : 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    result_valid = 1'b0;
    fetch_ready  = 1'b1;
    check("gen_timeout", int'(cyc >= BOUND), 0);
  endtask

  task automatic check_post(input string tag);
    check({tag, "_bank"}, bank_sel, exp_bank);
    check({tag, "_count"}, gen_count, exp_count);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int cyc;
    int drain;
    rst = 1'b1; frame_tick = 1'b0; pause = 1'b0; step = 1'b0;
    fetch_ready = 1'b1; result_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_fetch_valid", fetch_valid, 0);
    check("rst_fetch_addr", fetch_addr, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_bank", bank_sel, 0);
    check("rst_count", gen_count, 0);
    check("rst_gen_done", gen_done, 0);
    check("rst_ovf", wr_overflow, 0);
    check("rst_wdog", wdog_err, 0);
    rst = 1'b0;

    // Plain generation.
    run_gen(0, 4, 1'b0);
    check_post("gen1");

    // Paused tick does nothing; step still runs one generation.
    pause = 1'b1;
    @(posedge clk); #1; frame_tick = 1'b1;
    @(posedge clk); #1; frame_tick = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("pause_busy", busy, 0);
      @(posedge clk); #1;
    end
    run_gen(1, 4, 1'b0);
    pause = 1'b0;
    check_post("step");

    // Simultaneous tick and step: exactly one generation.
    run_gen(2, 4, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_post("tickstep");

    // Stalled fetch handshake.
    run_gen(0, 4, 1'b1);
    check_post("stall");
    check("ovf_before", wr_overflow, 0);

    // Fifth result overflows; generation still completes.
    run_gen(0, 5, 1'b0);
    check_post("ovf_gen");
    check("ovf_set", wr_overflow, 1);
    repeat (2) @(posedge clk);
    #1;
    check("ovf_sticky", wr_overflow, 1);

    // Reset after two accepted fetches.
    fetch_q.push_back(3); fetch_q.push_back(0);
    @(posedge clk); #1; frame_tick = 1'b1;
    @(posedge clk); #1; frame_tick = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_fetch_valid", fetch_valid, 0);
    check("mid_rst_fetch_addr", fetch_addr, 0);
    check("mid_rst_bank", bank_sel, 0);
    check("mid_rst_count", gen_count, 0);
    check("mid_rst_ovf", wr_overflow, 0);
    exp_bank  = 0;
    exp_count = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    run_gen(0, 4, 1'b0);
    check_post("after_rst");

`ifdef GEN_SCHED_WATCHDOG_EN
    // No results: watchdog aborts DRAIN without swapping.
    push_fetch_seq();
    @(posedge clk); #1; frame_tick = 1'b1;
    @(posedge clk); #1; frame_tick = 1'b0;
    cyc   = 0;
    drain = 0;
    while (busy && cyc < BOUND) begin
      if (!fetch_valid) drain++;
      @(posedge clk); #1;
      cyc++;
    end
    check("wdog_timeout", int'(cyc >= BOUND), 0);
    check("wdog_drain_cycles", drain, int'(WD));
    check("wdog_err", wdog_err, 1);
    check_post("wdog");
`else
    cyc   = 0;
    drain = 0;
    check("wdog_tied", wdog_err + cyc + drain, 0);
`endif

    repeat (2) @(posedge clk);
    #1;
    check("fetch_q_empty", fetch_q.size(), 0);
    check("wr_q_empty", wr_q.size(), 0);
    check("gen_q_empty", gen_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
